// File: rtl/rgb_cycle_monitor_if.sv
// rgb_cycle_monitor_if: LED pin lines and decoded status of the RGB cycle monitor
interface rgb_cycle_monitor_if;
  logic       rgb_r_n;
  logic       rgb_g_n;
  logic       rgb_b_n;
  logic [2:0] color;
  logic       color_valid;
  logic       locked;
  logic       seq_error;
  logic       timing_error;
  logic [7:0] err_count;
  modport master (
    output rgb_r_n, rgb_g_n, rgb_b_n,
    input  color, color_valid, locked, seq_error, timing_error, err_count
  );
  modport slave (
    input  rgb_r_n, rgb_g_n, rgb_b_n,
    output color, color_valid, locked, seq_error, timing_error, err_count
  );
endinterface

// File: rtl/rgb_cycle_monitor.sv
// rgb_cycle_monitor: debounces active-low RGB lines and checks colour order and dwell time
module rgb_cycle_monitor #(
  parameter int FADE_INTERVAL = 2000000,
  parameter int STABLE_CYCLES = 16,
  parameter int TOLERANCE     = 1024
) (
  input logic clk,
  input logic rst,
  rgb_cycle_monitor_if.slave bus
);
  localparam int DW = $clog2(FADE_INTERVAL + TOLERANCE + 2);
  localparam int SW = $clog2(STABLE_CYCLES);
  localparam logic [DW-1:0] DMAX = DW'(FADE_INTERVAL + TOLERANCE + 1);
  localparam logic [DW-1:0] DMIN = DW'(FADE_INTERVAL - TOLERANCE);
  localparam logic [SW-1:0] SACC = SW'(STABLE_CYCLES - 2);
  localparam logic [SW-1:0] SMAX = SW'(STABLE_CYCLES - 1);
  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;
  state_t state, state_n;
  logic [2:0] s1, s2, cand, dec, nxt, color;
  logic [SW-1:0] cnt;
  logic [DW-1:0] dwell;
  logic [7:0] err_count;
  logic acc, valid_c, in_seq, stall, seq_n, tim_n;
  logic color_valid, locked, seq_error, timing_error;
  assign bus.color        = color;
  assign bus.color_valid  = color_valid;
  assign bus.locked       = locked;
  assign bus.seq_error    = seq_error;
  assign bus.timing_error = timing_error;
  assign bus.err_count    = err_count;
  // Two-flop synchronizer; idle (unlit) lines read as 1
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= 3'b111;
      s2 <= 3'b111;
    end else begin
      s1 <= {bus.rgb_r_n, bus.rgb_g_n, bus.rgb_b_n};
      s2 <= s1;
    end
  // Candidate tracks the synchronized pattern; counter saturates so an accept fires once
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cand <= 3'b111;
      cnt  <= '0;
    end else if (s2 != cand) begin
      cand <= s2;
      cnt  <= '0;
    end else if (cnt != SMAX) begin
      cnt <= cnt + SW'(1);
    end
  // Active-low decode of the candidate into a colour code
  always_comb
    case (~cand)
      3'b100:  dec = 3'd0;
      3'b110:  dec = 3'd1;
      3'b010:  dec = 3'd2;
      3'b011:  dec = 3'd3;
      3'b001:  dec = 3'd4;
      3'b101:  dec = 3'd5;
      3'b000:  dec = 3'd6;
      default: dec = 3'd7;
    endcase
  assign acc     = s2 == cand && cnt == SACC && dec != color;
  assign valid_c = dec < 3'd6;
  assign nxt     = color == 3'd5 ? 3'd0 : color + 3'd1;
  assign in_seq  = valid_c && dec == nxt;
  assign stall   = dwell == DMAX;
  // Dwell counter holds the period so far, reading P on the cycle of the next accept
  always_ff @(posedge clk or posedge rst)
    if (rst) dwell <= '0;
    else if (acc) dwell <= DW'(1);
    else if (!stall) dwell <= dwell + DW'(1);
  // FSM state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= UNLOCKED;
    else state <= state_n;
  // FSM next state; an accept always takes priority over stall expiry
  always_comb begin
    state_n = state;
    case (state)
      UNLOCKED: if (acc && valid_c) state_n = ACQUIRE;
      ACQUIRE, LOCKED:
        if (acc) state_n = in_seq ? LOCKED : valid_c ? ACQUIRE : UNLOCKED;
        else if (state == LOCKED && stall) state_n = UNLOCKED;
      default: state_n = UNLOCKED;
    endcase
  end
  // FSM outputs: errors only while locked, and never both at once
  always_comb begin
    seq_n = state == LOCKED && acc && !in_seq;
    tim_n = state == LOCKED && (acc ? in_seq && dwell < DMIN : stall);
  end
  // Registered outputs and saturating error counter
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      color        <= 3'd6;
      color_valid  <= 1'b0;
      locked       <= 1'b0;
      seq_error    <= 1'b0;
      timing_error <= 1'b0;
      err_count    <= '0;
    end else begin
      color        <= acc ? dec : color;
      color_valid  <= acc;
      locked       <= state_n == LOCKED;
      seq_error    <= seq_n;
      timing_error <= tim_n;
      err_count    <= (seq_n || tim_n) && err_count != 8'hff ? err_count + 8'd1 : err_count;
    end
endmodule

// File: tb/tb_rgb_cycle_monitor.sv
// tb_rgb_cycle_monitor: scoreboard bench; stimulus queues expected pulses, a monitor checks them
module tb_rgb_cycle_monitor;
  typedef struct packed {
    logic [31:0] cyc;
    logic [2:0]  color;
    logic        cv, seq, tim, lk;
    logic [7:0]  err;
  } ev_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int compared = 0;
  int mismatched = 0;
  ev_t q[$];
  rgb_cycle_monitor_if bus();
  rgb_cycle_monitor #(.FADE_INTERVAL(64), .STABLE_CYCLES(4), .TOLERANCE(4)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Monitor: every output pulse must match the oldest expected event, cycle included
  always @(negedge clk)
    if (!rst && (bus.color_valid || bus.seq_error || bus.timing_error)) begin
      ev_t a, e;
      a = {32'(cyc), bus.color, bus.color_valid, bus.seq_error, bus.timing_error, bus.locked, bus.err_count};
      compared++;
      if (q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_event: got cyc=%0d color=%0d cv=%0b seq=%0b tim=%0b lk=%0b err=%0d, want none",
                 a.cyc, a.color, a.cv, a.seq, a.tim, a.lk, a.err);
      end else begin
        e = q.pop_front();
        if (a !== e) begin
          mismatched++;
          $display("FAIL event: got cyc=%0d color=%0d cv=%0b seq=%0b tim=%0b lk=%0b err=%0d, want cyc=%0d color=%0d cv=%0b seq=%0b tim=%0b lk=%0b err=%0d",
                   a.cyc, a.color, a.cv, a.seq, a.tim, a.lk, a.err, e.cyc, e.color, e.cv, e.seq, e.tim, e.lk, e.err);
        end
      end
    end
  function automatic logic [2:0] pins(input logic [2:0] c);
    case (c)
      3'd0: return 3'b011;
      3'd1: return 3'b001;
      3'd2: return 3'b101;
      3'd3: return 3'b100;
      3'd4: return 3'b110;
      3'd5: return 3'b010;
      3'd6: return 3'b111;
      default: return 3'b000;
    endcase
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [2:0] c);
    {bus.rgb_r_n, bus.rgb_g_n, bus.rgb_b_n} = pins(c);
  endtask
  task automatic expect_ev(input int at, input logic [2:0] c, input logic cv, input logic seq,
                           input logic tim, input logic lk, input logic [7:0] err);
    q.push_back({32'(at), c, cv, seq, tim, lk, err});
  endtask
  // Drive a colour, expect its accept 6 cycles later, then hold it
  task automatic send(input logic [2:0] c, input int hold, input logic seq, input logic tim,
                      input logic lk, input logic [7:0] err);
    drive(c);
    expect_ev(cyc + 6, c, 1'b1, seq, tim, lk, err);
    step(hold);
  endtask
  task automatic chk_reset_outputs();
    chk("rst_color", 32'(bus.color), 32'd6);
    chk("rst_pulses", 32'({bus.color_valid, bus.seq_error, bus.timing_error}), 32'd0);
    chk("rst_locked", 32'(bus.locked), 32'd0);
    chk("rst_err_count", 32'(bus.err_count), 32'd0);
  endtask
  initial begin
    int t;
    drive(3'd6);
    step(3);
    chk_reset_outputs();
    chk("rst_color_valid", 32'(bus.color_valid), 32'd0);
    rst = 1'b0;
    step(5);
    // Nominal: two full loops, lock on the first YELLOW
    for (int l = 0; l < 2; l++)
      for (int c = 0; c < 6; c++)
        send(3'(c), 64, 1'b0, 1'b0, !(l == 0 && c == 0), 8'd0);
    send(3'd0, 64, 1'b0, 1'b0, 1'b1, 8'd0);
    send(3'd1, 64, 1'b0, 1'b0, 1'b1, 8'd0);
    send(3'd2, 20, 1'b0, 1'b0, 1'b1, 8'd0);
    // Glitch: 3 cycles of BLUE while locked on GREEN is filtered out
    drive(3'd4);
    step(3);
    drive(3'd2);
    step(41);
    chk("glitch_color", 32'(bus.color), 32'd2);
    chk("glitch_locked", 32'(bus.locked), 32'd1);
    // Skip GREEN->BLUE, then re-lock on MAGENTA without a timed first dwell
    send(3'd4, 64, 1'b1, 1'b0, 1'b0, 8'd1);
    send(3'd5, 64, 1'b0, 1'b0, 1'b1, 8'd1);
    send(3'd0, 64, 1'b0, 1'b0, 1'b1, 8'd1);
    send(3'd1, 64, 1'b0, 1'b0, 1'b1, 8'd1);
    send(3'd2, 64, 1'b0, 1'b0, 1'b1, 8'd1);
    // Short dwell of 58 cycles, then stall 69 cycles after the BLUE accept
    send(3'd3, 58, 1'b0, 1'b0, 1'b1, 8'd1);
    t = cyc;
    drive(3'd4);
    expect_ev(t + 6, 3'd4, 1'b1, 1'b0, 1'b1, 1'b1, 8'd2);
    expect_ev(t + 6 + 69, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3);
    step(80);
    chk("stall_locked", 32'(bus.locked), 32'd0);
    // Dwell boundaries: 60 is accepted, 59 is short; then OFF breaks the sequence
    send(3'd5, 64, 1'b0, 1'b0, 1'b0, 8'd3);
    send(3'd0, 60, 1'b0, 1'b0, 1'b1, 8'd3);
    send(3'd1, 59, 1'b0, 1'b0, 1'b1, 8'd3);
    send(3'd2, 64, 1'b0, 1'b1, 1'b1, 8'd4);
    send(3'd6, 64, 1'b1, 1'b0, 1'b0, 8'd5);
    send(3'd0, 64, 1'b0, 1'b0, 1'b0, 8'd5);
    send(3'd1, 30, 1'b0, 1'b0, 1'b1, 8'd5);
    chk("pre_reset_err_count", 32'(bus.err_count), 32'd5);
    // Asynchronous reset between clock edges while locked mid-dwell
    #3;
    rst = 1'b1;
    #2;
    chk_reset_outputs();
    step(2);
    rst = 1'b0;
    expect_ev(cyc + 6, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    step(64);
    send(3'd2, 64, 1'b0, 1'b0, 1'b1, 8'd0);
    send(3'd3, 20, 1'b0, 1'b0, 1'b1, 8'd0);
    chk("final_locked", 32'(bus.locked), 32'd1);
    chk("pending_events", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
